// File: rtl/systolic_skew_feeder_if.sv
// Operand write port, run control and skewed edge streams of the systolic skew feeder.
// The master side loads operands and starts runs; the slave side is the feeder itself.
interface systolic_skew_feeder_if #(
    parameter int unsigned DATA_W = 8
);
    logic              wr_en;
    logic              wr_sel;
    logic [3:0]        wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              start;
    logic              busy;
    logic              arr_clr;
    logic              done;
    logic [DATA_W-1:0] inp_west0;
    logic [DATA_W-1:0] inp_west4;
    logic [DATA_W-1:0] inp_west8;
    logic [DATA_W-1:0] inp_west12;
    logic [DATA_W-1:0] inp_north0;
    logic [DATA_W-1:0] inp_north1;
    logic [DATA_W-1:0] inp_north2;
    logic [DATA_W-1:0] inp_north3;

    modport master (
        output wr_en, wr_sel, wr_addr, wr_data, start,
        input  busy, arr_clr, done,
        input  inp_west0, inp_west4, inp_west8, inp_west12,
        input  inp_north0, inp_north1, inp_north2, inp_north3
    );

    modport slave (
        input  wr_en, wr_sel, wr_addr, wr_data, start,
        output busy, arr_clr, done,
        output inp_west0, inp_west4, inp_west8, inp_west12,
        output inp_north0, inp_north1, inp_north2, inp_north3
    );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Operand store and diagonal wavefront generator for the 4x4 systolic multiplier.
// Row i of A and column j of B are delayed by i and j cycles respectively.
module systolic_skew_feeder #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input logic                   clk,
    input logic                   rst,
    systolic_skew_feeder_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StFeed,
        StDrain,
        StFin
    } state_e;

    localparam logic [2:0] FeedLast  = 3'd6;
    localparam logic [3:0] DrainLast = (DRAIN_CYCLES == 0) ? 4'd0 : 4'(DRAIN_CYCLES - 1);

    state_e            state_q, state_d;
    logic [2:0]        step_q, step_d;
    logic [3:0]        drain_q, drain_d;

    logic [DATA_W-1:0] bank_a [16];
    logic [DATA_W-1:0] bank_b [16];

    logic              busy_q, busy_d;
    logic              arr_clr_q, arr_clr_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] west_q [4];
    logic [DATA_W-1:0] west_d [4];
    logic [DATA_W-1:0] north_q [4];
    logic [DATA_W-1:0] north_d [4];
    logic [3:0]        lag;

    // Operand banks accept writes only while the FSM is idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                bank_a[i] <= '0;
                bank_b[i] <= '0;
            end
        end else if (bus.wr_en && (state_q == StIdle)) begin
            if (bus.wr_sel) begin
                bank_b[bus.wr_addr] <= bus.wr_data;
            end else begin
                bank_a[bus.wr_addr] <= bus.wr_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            step_q  <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        drain_d = drain_q;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StClear;
                end
            end
            StClear: begin
                state_d = StFeed;
                step_d  = '0;
            end
            StFeed: begin
                if (step_q == FeedLast) begin
                    step_d  = '0;
                    drain_d = '0;
                    if (DRAIN_CYCLES == 0) begin
                        state_d = StFin;
                    end else begin
                        state_d = StDrain;
                    end
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            StDrain: begin
                if (drain_q == DrainLast) begin
                    state_d = StFin;
                end else begin
                    drain_d = drain_q + 4'd1;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register on the same edge as the state.
    always_comb begin
        busy_d    = state_d inside {StClear, StFeed, StDrain};
        arr_clr_d = (state_d == StClear);
        done_d    = (state_d == StFin);
        lag       = '0;
        for (int i = 0; i < 4; i++) begin
            west_d[i]  = '0;
            north_d[i] = '0;
            // Negative lags wrap above 3 and fall outside the diagonal window.
            lag = {1'b0, step_d} - 4'(i);
            if ((state_d == StFeed) && (lag <= 4'd3)) begin
                west_d[i]  = bank_a[{2'(i), lag[1:0]}];
                north_d[i] = bank_b[{lag[1:0], 2'(i)}];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q    <= 1'b0;
            arr_clr_q <= 1'b0;
            done_q    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                west_q[i]  <= '0;
                north_q[i] <= '0;
            end
        end else begin
            busy_q    <= busy_d;
            arr_clr_q <= arr_clr_d;
            done_q    <= done_d;
            west_q    <= west_d;
            north_q   <= north_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.arr_clr    = arr_clr_q;
    assign bus.done       = done_q;
    assign bus.inp_west0  = west_q[0];
    assign bus.inp_west4  = west_q[1];
    assign bus.inp_west8  = west_q[2];
    assign bus.inp_west12 = west_q[3];
    assign bus.inp_north0 = north_q[0];
    assign bus.inp_north1 = north_q[1];
    assign bus.inp_north2 = north_q[2];
    assign bus.inp_north3 = north_q[3];

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: a DRAIN_CYCLES=3 and a DRAIN_CYCLES=0 instance share stimulus
// and are compared every cycle against a run-position model of the wavefront timing.
module tb_systolic_skew_feeder;
    localparam int unsigned DATA_W = 8;

    typedef struct packed {
        logic            busy;
        logic            clr;
        logic            done;
        logic [3:0][7:0] west;
        logic [3:0][7:0] north;
    } obs_t;

    typedef struct {
        logic       start;
        logic       busy;
        logic       clr;
        logic       done3;
        logic       done0;
        logic [7:0] w0;
        logic [7:0] w4;
        logic [7:0] n0;
        logic [7:0] n3;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    systolic_skew_feeder_if #(.DATA_W(DATA_W)) bus_d3 ();
    systolic_skew_feeder_if #(.DATA_W(DATA_W)) bus_d0 ();

    systolic_skew_feeder #(.DATA_W(DATA_W), .DRAIN_CYCLES(3)) dut_d3 (
        .clk(clk), .rst(rst), .bus(bus_d3)
    );
    systolic_skew_feeder #(.DATA_W(DATA_W), .DRAIN_CYCLES(0)) dut_d0 (
        .clk(clk), .rst(rst), .bus(bus_d0)
    );

    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    int         drain_of [2] = '{3, 0};
    // pos: 0 = idle, 1 = clear, 2..8 = feed t=pos-2, then drain, then fin at 9+drain.
    int         pos [2];
    logic [7:0] ma [2][16];
    logic [7:0] mb [2][16];

    function automatic obs_t model_out(int d);
        obs_t o    = '0;
        int   last = 9 + drain_of[d];
        int   p    = pos[d];
        o.busy = (p >= 1) && (p < last);
        o.clr  = (p == 1);
        o.done = (p == last);
        if (p >= 2 && p <= 8) begin
            for (int i = 0; i < 4; i++) begin
                int k = p - 2 - i;
                if (k >= 0 && k <= 3) begin
                    o.west[i]  = ma[d][i*4+k];
                    o.north[i] = mb[d][k*4+i];
                end
            end
        end
        return o;
    endfunction

    function automatic obs_t dut_out(int d);
        obs_t o;
        if (d == 0) begin
            o = {bus_d3.busy, bus_d3.arr_clr, bus_d3.done,
                 bus_d3.inp_west12, bus_d3.inp_west8, bus_d3.inp_west4, bus_d3.inp_west0,
                 bus_d3.inp_north3, bus_d3.inp_north2, bus_d3.inp_north1, bus_d3.inp_north0};
        end else begin
            o = {bus_d0.busy, bus_d0.arr_clr, bus_d0.done,
                 bus_d0.inp_west12, bus_d0.inp_west8, bus_d0.inp_west4, bus_d0.inp_west0,
                 bus_d0.inp_north3, bus_d0.inp_north2, bus_d0.inp_north1, bus_d0.inp_north0};
        end
        return o;
    endfunction

    task automatic check_obs(string name);
        for (int d = 0; d < 2; d++) begin
            obs_t got = dut_out(d);
            obs_t exp = model_out(d);
            n_checks++;
            if (got === exp) n_pass++;
            else $display("FAIL %s drain=%0d cyc=%0d got=%h exp=%h",
                          name, drain_of[d], cyc, got, exp);
        end
    endtask

    task automatic check_val(string name, longint got, longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
    endtask

    task automatic drive(input logic we, input logic sel, input logic [3:0] addr,
                         input logic [7:0] data, input logic st);
        bus_d3.wr_en = we;   bus_d0.wr_en = we;
        bus_d3.wr_sel = sel; bus_d0.wr_sel = sel;
        bus_d3.wr_addr = addr; bus_d0.wr_addr = addr;
        bus_d3.wr_data = data; bus_d0.wr_data = data;
        bus_d3.start = st;   bus_d0.start = st;
    endtask

    task automatic step(input logic we, input logic sel, input logic [3:0] addr,
                        input logic [7:0] data, input logic st);
        drive(we, sel, addr, data, st);
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (pos[d] == 0) begin
                if (we) begin
                    if (sel) mb[d][addr] = data;
                    else ma[d][addr] = data;
                end
                if (st) pos[d] = 1;
            end else if (pos[d] == 9 + drain_of[d]) begin
                pos[d] = 0;
            end else begin
                pos[d]++;
            end
        end
        cyc++;
        #1;
        check_obs("scoreboard");
    endtask

    task automatic tick();
        step(1'b0, 1'b0, 4'd0, 8'd0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (dut_out(d) === '0) n_pass++;
            else $display("FAIL async_reset drain=%0d cyc=%0d got=%h exp=0",
                          drain_of[d], cyc, dut_out(d));
            pos[d] = 0;
            for (int i = 0; i < 16; i++) begin
                ma[d][i] = 8'd0;
                mb[d][i] = 8'd0;
            end
        end
        @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    task automatic run_capture(output int w0_t0);
        w0_t0 = -1;
        step(1'b0, 1'b0, 4'd0, 8'd0, 1'b1);
        for (int r = 1; r <= 12; r++) begin
            tick();
            if (r == 1) w0_t0 = int'(bus_d3.inp_west0);
        end
    endtask

    initial begin
        vec_t         tbl [13];
        int           w;
        int           clr3, clr0;
        int           done3_at [$];
        int           done0_at [$];
        logic [63:0]  acc;
        logic [35:0]  got_v, exp_v;

        // Identity A, B[k][j] = 4k+j+1: per-cycle expectations after the start edge.
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0,  8'd0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 8'd0, 8'd1,  8'd0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd5,  8'd0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1, 8'd9,  8'd0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd13, 8'd4};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0,  8'd8};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0,  8'd12};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0,  8'd16};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0,  8'd0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0,  8'd0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0,  8'd0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0,  8'd0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0,  8'd0};

        drive(1'b0, 1'b0, 4'd0, 8'd0, 1'b0);
        #1;
        do_reset();
        tick();
        tick();

        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 4'(i), ((i / 4) == (i % 4)) ? 8'd1 : 8'd0, 1'b0);
            step(1'b1, 1'b1, 4'(i), 8'(i + 1), 1'b0);
        end
        for (int r = 0; r < 13; r++) begin
            step(1'b0, 1'b0, 4'd0, 8'd0, tbl[r].start);
            got_v = {bus_d3.busy, bus_d3.arr_clr, bus_d3.done, bus_d0.done,
                     bus_d3.inp_west0, bus_d3.inp_west4, bus_d3.inp_north0, bus_d3.inp_north3};
            exp_v = {tbl[r].busy, tbl[r].clr, tbl[r].done3, tbl[r].done0,
                     tbl[r].w0, tbl[r].w4, tbl[r].n0, tbl[r].n3};
            n_checks++;
            if (got_v === exp_v) n_pass++;
            else $display("FAIL identity_row%0d got=%h exp=%h", r, got_v, exp_v);
        end

        // Full scale: every element 255, probe the window edges t-i=-1 and t-i=4.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 4'(i), 8'd255, 1'b0);
            step(1'b1, 1'b1, 4'(i), 8'd255, 1'b0);
        end
        step(1'b0, 1'b0, 4'd0, 8'd0, 1'b1);
        for (int r = 1; r <= 12; r++) begin
            tick();
            if (r == 1) begin
                check_val("fs_west0_t0", bus_d3.inp_west0, 255);
                check_val("fs_west4_t0_pre_window", bus_d3.inp_west4, 0);
            end
            if (r == 5) begin
                check_val("fs_west0_t4_post_window", bus_d3.inp_west0, 0);
                check_val("fs_west4_t4", bus_d3.inp_west4, 255);
            end
        end

        // Write during FEED is dropped; the same write in IDLE lands.
        step(1'b1, 1'b0, 4'd0, 8'd3, 1'b0);
        step(1'b0, 1'b0, 4'd0, 8'd0, 1'b1);
        for (int r = 1; r <= 12; r++) begin
            if (r == 3) step(1'b1, 1'b0, 4'd0, 8'd7, 1'b0);
            else tick();
        end
        run_capture(w);
        check_val("busy_write_ignored", w, 3);
        step(1'b1, 1'b0, 4'd0, 8'd7, 1'b0);
        run_capture(w);
        check_val("idle_write_applied", w, 7);
        run_capture(w);
        check_val("rerun_same_stream", w, 7);

        // Start held high: runs separated by one idle cycle.
        clr3 = 0;
        clr0 = 0;
        for (int c = 0; c < 54; c++) begin
            step(1'b0, 1'b0, 4'd0, 8'd0, c < 40);
            if (bus_d3.done) done3_at.push_back(cyc);
            if (bus_d0.done) done0_at.push_back(cyc);
            if (bus_d3.arr_clr) clr3++;
            if (bus_d0.arr_clr) clr0++;
        end
        check_val("b2b_clr_d3", clr3, 4);
        check_val("b2b_clr_d0", clr0, 4);
        check_val("b2b_done_cnt_d3", done3_at.size(), 4);
        check_val("b2b_done_cnt_d0", done0_at.size(), 4);
        for (int i = 1; i < done3_at.size(); i++)
            check_val("b2b_gap_d3", done3_at[i] - done3_at[i-1], 13);
        for (int i = 1; i < done0_at.size(); i++)
            check_val("b2b_gap_d0", done0_at[i] - done0_at[i-1], 10);

        // Asynchronous reset at FEED t=3, then a run must stream only zeros.
        step(1'b0, 1'b0, 4'd0, 8'd0, 1'b1);
        for (int r = 1; r <= 4; r++) tick();
        do_reset();
        tick();
        acc = '0;
        step(1'b0, 1'b0, 4'd0, 8'd0, 1'b1);
        for (int r = 1; r <= 12; r++) begin
            tick();
            acc |= {dut_out(0).west, dut_out(0).north};
        end
        check_val("post_reset_streams_zero", (acc == '0) ? 1 : 0, 1);

        for (int c = 0; c < 400; c++) begin
            step($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                 $urandom_range(0, 11) == 0);
        end
        for (int c = 0; c < 15; c++) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/systolic_skew_feeder.md
# systolic_skew_feeder

Upstream stage of the 4x4 8-bit systolic multiplier. Holds operand matrices A (4x4) and B (4x4) written over a simple register port. On a start pulse it clears the array and emits the diagonally skewed operand wavefronts on the west and north edges, so that PE(i,j) accumulates sum_k A[i][k]*B[k][j]. After a drain period it signals completion.

## Interface
- DATA_W, 8, operand width; fixed at 8 for the current array.
- DRAIN_CYCLES, 3, zero-input cycles appended after the last wavefront (range 0-15).
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- wr_en  in  1  operand write strobe
- wr_sel  in  1  0 = matrix A, 1 = matrix B
- wr_addr  in  4  element index, row*4+col
- wr_data  in  8  element value, unsigned
- start  in  1  single-cycle request to run a multiply
- busy  out  1  high from the CLEAR state through the last DRAIN cycle
- arr_clr  out  1  one-cycle accumulator clear, driven to the array reset
- inp_west0, inp_west4, inp_west8, inp_west12  out  8 each  row-0..3 A stream to the array's west edge
- inp_north0..inp_north3  out  8 each  column-0..3 B stream to the array's north edge
- done  out  1  one-cycle completion pulse

## Operation
- Storage: two 16x8 register banks. A write with wr_en=1 in IDLE stores wr_data at bank[wr_sel][wr_addr]. Writes while busy=1 are ignored.
- States: IDLE -> CLEAR -> FEED -> DRAIN -> FIN -> IDLE.
- IDLE: start=1 moves to CLEAR. All stream outputs are 0.
- CLEAR: one cycle. arr_clr=1, streams are 0.
- FEED: 7 cycles, t=0..6, using a 3-bit step counter.
  - inp_west(4i) = A[i][t-i] when 0<=t-i<=3, else 0.
  - inp_north(j) = B[t-j][j] when 0<=t-j<=3, else 0.
- DRAIN: DRAIN_CYCLES cycles with all streams at 0. This lets the last wavefront propagate to PE(3,3). With DRAIN_CYCLES=0 the FSM goes straight from FEED to FIN.
- FIN: one cycle. done=1, busy=0, then return to IDLE.
- start is ignored in every state except IDLE, including FIN.
- start and wr_en asserted together in IDLE: the write completes and the run uses the newly written value.
- Bank contents persist across runs and are not cleared by a run. A second start with no new writes reproduces identical streams.
- Reset (asynchronous, any state, including mid-FEED):
  - state=IDLE, step counter=0.
  - busy=0, done=0, arr_clr=0, all streams=0.
  - Banks cleared to 0.
  - Any in-flight run is abandoned without a done pulse.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- With start sampled high at rising edge k (state IDLE):
  - Cycle k+1: CLEAR, arr_clr=1, busy=1.
  - Cycles k+2..k+8: FEED, t=0..6.
  - Cycles k+9..k+8+DRAIN_CYCLES: DRAIN.
  - Cycle k+9+DRAIN_CYCLES: done=1, busy=0.
- Earliest next accepted start: the edge that ends the FIN cycle, i.e. a start held high during FIN. That start is ignored; the next edge, with FSM in IDLE, is accepted.
- A write becomes visible to the stream on the cycle after its edge.
- Step counter wraps only under FSM control. It is reset to 0 on every entry to FEED.

## Test plan
- Reset mid-run: start, then assert rst during FEED t=3 → all outputs 0 immediately (asynchronous). After release: IDLE, no done pulse, banks read back 0 (a subsequent start streams all zeros).
- Identity check: A = I, B[k][j] = 4k+j+1. Start → west0 sequence over t=0..6 is 1,0,0,0,0,0,0; west4 is 0,0,1,0,0,0,0 (skewed by one per row); north3 is 0,0,0,4,8,12,16. Downstream array result equals B; done at k+12.
- Full-scale: all A and B elements = 255 → every stream value is 255 within its diagonal window and 0 outside it; array result in every cell is 4*65025 truncated to the array's 16-bit width. Checks window edges t-i=-1 and t-i=4.
- Write while busy: during FEED write A[0][0]=7 → ignored. The current and next run stream the original A[0][0]; after FIN the same write succeeds.
- Back-to-back: start held high continuously from IDLE → runs separated by exactly one IDLE cycle, done pulses 13 cycles apart (DRAIN_CYCLES=3), arr_clr once per run.
- DRAIN_CYCLES=0 build: done in cycle k+9, immediately after FEED t=6.
